adc_spi_reader: RTL

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_reader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/adc_spi_reader.sv
// SPI reader for a serial ADC: frames cs/s_clk, discards LEAD_BITS, captures 8 data bits MSB first.
// Define ADC_SPI_READER_AVG_EN to publish the truncated mean of every four frames instead of each frame.
module adc_spi_reader #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned LEAD_BITS  = 3,
   parameter int unsigned GAP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       s_data,
   output logic       s_clk,
   output logic       cs,
   output logic [7:0] sample,
   output logic       sample_valid,
   output logic       busy
);

   typedef enum logic [1:0] {ST_GAP, ST_SETUP, ST_SHIFT, ST_DONE} state_t;

   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [4:0]  DATA_LO  = 5'(LEAD_BITS);

   state_t      r_state;
   logic [15:0] r_gap_cnt;
   logic [7:0]  r_div_cnt;
   logic [3:0]  r_bit_cnt;
   logic        r_cs;
   logic        r_sclk;
   logic [7:0]  r_shift;
   logic [7:0]  r_sample;
   logic        r_valid;

   logic        w_div_end;
   logic [4:0]  w_rel_idx;
   logic        w_in_data;

   assign w_div_end = (r_div_cnt == DIV_LAST);
   // Bits before the data window wrap to a large value, so one compare covers both ends.
   assign w_rel_idx = {1'b0, r_bit_cnt} - DATA_LO;
   assign w_in_data = (w_rel_idx < 5'd8);

`ifdef ADC_SPI_READER_AVG_EN
   logic [9:0]  r_acc;
   logic [1:0]  r_frm_cnt;
   logic [9:0]  w_acc_sum;

   assign w_acc_sum = r_acc + {2'b00, r_shift};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_GAP;
         r_gap_cnt <= '0;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_cs      <= 1'b1;
         r_sclk    <= 1'b1;
         r_shift   <= '0;
         r_sample  <= '0;
         r_valid   <= 1'b0;
`ifdef ADC_SPI_READER_AVG_EN
         r_acc     <= '0;
         r_frm_cnt <= '0;
`endif
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_GAP: begin
               r_cs   <= 1'b1;
               r_sclk <= 1'b1;
               // Counter saturates at the end of the gap so a late en starts the frame at once.
               if (r_gap_cnt == GAP_LAST) begin
                  if (en) begin
                     r_state   <= ST_SETUP;
                     r_cs      <= 1'b0;
                     r_gap_cnt <= '0;
                     r_div_cnt <= '0;
                     r_bit_cnt <= '0;
                     r_shift   <= '0;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt + 16'd1;
               end
            end

            ST_SETUP: begin
               if (w_div_end) begin
                  r_div_cnt <= '0;
                  r_sclk    <= 1'b0;
                  r_state   <= ST_SHIFT;
               end else begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end
            end

            ST_SHIFT: begin
               if (!w_div_end) begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end else begin
                  r_div_cnt <= '0;
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                     if (w_in_data)
                        r_shift <= {r_shift[6:0], s_data};
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd15) begin
                        r_state <= ST_DONE;
                        r_cs    <= 1'b1;
`ifdef ADC_SPI_READER_AVG_EN
                        if (r_frm_cnt == 2'd3) begin
                           r_sample  <= w_acc_sum[9:2];
                           r_valid   <= 1'b1;
                           r_acc     <= '0;
                           r_frm_cnt <= '0;
                        end else begin
                           r_acc     <= w_acc_sum;
                           r_frm_cnt <= r_frm_cnt + 2'd1;
                        end
`else
                        r_sample <= r_shift;
                        r_valid  <= 1'b1;
`endif
                     end else begin
                        r_sclk <= 1'b0;
                     end
                  end
               end
            end

            ST_DONE: begin
               r_state   <= ST_GAP;
               r_gap_cnt <= '0;
            end

            default: r_state <= ST_GAP;
         endcase
      end
   end

   assign s_clk        = r_sclk;
   assign cs           = r_cs;
   assign busy         = ~r_cs;
   assign sample       = r_sample;
   assign sample_valid = r_valid;

endmodule
